// File: rtl/mhd_pkg.sv
// Shared types and elaboration helpers for the Hamming-distance pattern generator.
package mhd_pkg;

  localparam int unsigned DefWidth = 9;
  localparam int unsigned DefMhd   = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush
  } state_e;

  // Wide enough to hold WIDTH+1, so an out-of-range hd is still representable.
  function automatic int unsigned hd_width(input int unsigned width);
    return $clog2(width + 2);
  endfunction

  function automatic int unsigned binom(input int unsigned n, input int unsigned k);
    int unsigned r;
    r = 1;
    if (k > n) return 0;
    for (int unsigned i = 0; i < k; i++) begin
      r = r * (n - i) / (i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/mhd_next_comb.sv
// Single-cycle next-combination step: next larger WIDTH-bit value with the same popcount,
// plus a flag marking the final (highest) mask for the given hd.
module mhd_next_comb
  import mhd_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned HD_W  = hd_width(WIDTH)
) (
  input  logic [WIDTH-1:0] mask,
  input  logic [HD_W-1:0]  hd,
  output logic [WIDTH-1:0] next,
  output logic             is_last
);

  logic [WIDTH:0]   m;
  logic [WIDTH:0]   low;
  logic [WIDTH:0]   ripple;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] ones;
  logic [HD_W-1:0]  tz;
  logic [HD_W-1:0]  sh;
  logic [WIDTH:0]   lo_m;
  logic [WIDTH:0]   hi_m;

  always_comb begin
    m      = {1'b0, mask};
    low    = m & (~m + (WIDTH+1)'(1));
    ripple = m + low;
    diff   = m ^ ripple;
    // low is one-hot (or zero), so this is a plain trailing-zero encode
    tz = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      if (low[i]) tz = HD_W'(i);
    end
    ones = WIDTH'(diff >> (32'(tz) + 2));
    next = ripple[WIDTH-1:0] | ones;

    sh      = HD_W'(WIDTH) - hd;
    lo_m    = ((WIDTH+1)'(1) << hd) - (WIDTH+1)'(1);
    hi_m    = lo_m << sh;
    is_last = (m == hi_m);
  end

endmodule

// File: rtl/mhd_pattern_gen.sv
// Streams every (base, base ^ mask) pair with popcount(mask) == hd over valid/ready.
// Optional handshake counter with binomial self-check: define MHD_GEN_COUNT_EN.
module mhd_pattern_gen
  import mhd_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned MHD   = DefMhd,
  parameter int unsigned HD_W  = hd_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [HD_W-1:0]  hd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_last,
  output logic             over_mhd,
  output logic             busy,
  output logic             done,
`ifdef MHD_GEN_COUNT_EN
  output logic [WIDTH-1:0] pat_cnt,
`endif
  output logic             err
);

  state_e           state_q;
  logic [WIDTH-1:0] mask_q;
  logic [HD_W-1:0]  hd_q;
  logic [WIDTH-1:0] mask_next;
  logic             mask_last;
  logic [WIDTH-1:0] load_mask;

  mhd_next_comb #(
    .WIDTH(WIDTH),
    .HD_W (HD_W)
  ) u_next_comb (
    .mask   (mask_q),
    .hd     (hd_q),
    .next   (mask_next),
    .is_last(mask_last)
  );

  assign load_mask = WIDTH'(((WIDTH+1)'(1) << hd) - (WIDTH+1)'(1));
  assign out_b     = out_a ^ mask_q;
  assign out_last  = out_valid & mask_last;
  assign busy      = (state_q != StIdle);

`ifdef MHD_GEN_COUNT_EN
  logic [WIDTH-1:0] binom_rom [WIDTH+1];
  for (genvar k = 0; k <= WIDTH; k++) begin : g_rom
    assign binom_rom[k] = WIDTH'(binom(WIDTH, k));
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mask_q    <= '0;
      hd_q      <= '0;
      out_a     <= '0;
      out_valid <= 1'b0;
      over_mhd  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef MHD_GEN_COUNT_EN
      pat_cnt   <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            out_a    <= base;
            hd_q     <= hd;
            err      <= 1'b0;
            over_mhd <= (hd > HD_W'(MHD));
`ifdef MHD_GEN_COUNT_EN
            pat_cnt  <= '0;
`endif
            if (hd > HD_W'(WIDTH)) begin
              err  <= 1'b1;
              done <= 1'b1;
            end else begin
              mask_q    <= load_mask;
              out_valid <= 1'b1;
              state_q   <= StRun;
            end
          end
        end
        StRun: begin
          if (out_ready) begin
`ifdef MHD_GEN_COUNT_EN
            pat_cnt <= pat_cnt + WIDTH'(1);
            if (mask_last && (pat_cnt + WIDTH'(1) != binom_rom[hd_q])) err <= 1'b1;
`endif
            if (mask_last) begin
              out_valid <= 1'b0;
              state_q   <= StFlush;
            end else begin
              mask_q <= mask_next;
            end
          end
        end
        StFlush: begin
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
